// File: rtl/spi_frame_master.sv
// Frame-level SPI master (mode 0): shifts a {cmd, addr, wdata} 64-bit frame out MSB first and
// captures 32 bits of miso during the data phase. All pin-side outputs are registered.
module spi_frame_master #(
   parameter int unsigned HALF_DIV = 2,
   parameter int unsigned GAP_CYC  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        ready,
   input  logic [7:0]  cmd,
   input  logic [23:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        sck,
   output logic        cs,
   output logic        mosi,
   input  logic        miso
);

   localparam int unsigned MaxCnt = (HALF_DIV > GAP_CYC) ? HALF_DIV : GAP_CYC;
   localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

   localparam logic [CntW-1:0] HalfLast = CntW'(HALF_DIV - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);
   localparam logic [CntW-1:0] GapPrev  = CntW'((GAP_CYC > 1) ? (GAP_CYC - 2) : 0);

   typedef enum logic [2:0] {
      StIdle,
      StShiftLo,
      StShiftHi,
      StTrail,
      StGap
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] div_q;
   logic [5:0]      bit_q;
   logic [62:0]     tx_q;  // frame bits still to send; frame[63] goes straight to mosi
   logic [31:0]     rx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         ready   <= 1'b1;
         rdata   <= '0;
         done    <= 1'b0;
         sck     <= 1'b0;
         cs      <= 1'b1;
         mosi    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  tx_q    <= {cmd[6:0], addr, wdata};
                  mosi    <= cmd[7];
                  bit_q   <= '0;
                  div_q   <= '0;
                  cs      <= 1'b0;
                  ready   <= 1'b0;
                  state_q <= StShiftLo;
               end
            end
            StShiftLo: begin
               if (div_q == HalfLast) begin
                  div_q   <= '0;
                  sck     <= 1'b1;
                  state_q <= StShiftHi;
                  // Sample on the same edge that raises sck; only data-phase bits are kept.
                  if (bit_q[5]) begin
                     rx_q <= {rx_q[30:0], miso};
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            StShiftHi: begin
               if (div_q == HalfLast) begin
                  div_q <= '0;
                  sck   <= 1'b0;
                  if (bit_q != 6'd63) begin
                     bit_q   <= bit_q + 1'b1;
                     mosi    <= tx_q[62];
                     tx_q    <= {tx_q[61:0], 1'b0};
                     state_q <= StShiftLo;
                  end else begin
                     state_q <= StTrail;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            StTrail: begin
               if (div_q == HalfLast) begin
                  div_q   <= '0;
                  cs      <= 1'b1;
                  mosi    <= 1'b0;
                  state_q <= StGap;
                  // With a one-cycle gap the first gap cycle is also the last one.
                  if (GAP_CYC == 1) begin
                     done  <= 1'b1;
                     rdata <= rx_q;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            StGap: begin
               if (div_q == GapLast) begin
                  div_q   <= '0;
                  ready   <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  div_q <= div_q + 1'b1;
                  if (div_q == GapPrev) begin
                     done  <= 1'b1;
                     rdata <= rx_q;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: three instances (default, HALF_DIV=1/GAP_CYC=1, HALF_DIV=5)
// watched by a pin-level monitor that rebuilds each frame and checks it against a scoreboard.
module tb_spi_frame_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_w   [3];
   logic        req_w   [3];
   logic        ready_w [3];
   logic        done_w  [3];
   logic        sck_w   [3];
   logic        cs_w    [3];
   logic        mosi_w  [3];
   logic        miso_w  [3];
   logic [7:0]  cmd_w   [3];
   logic [23:0] addr_w  [3];
   logic [31:0] wdata_w [3];
   logic [31:0] rdata_w [3];

   int hd_p  [3] = '{2, 1, 5};
   int gap_p [3] = '{4, 1, 4};

   spi_frame_master #(.HALF_DIV(2), .GAP_CYC(4)) u_dut0 (
      .clk(clk), .rst(rst_w[0]), .req(req_w[0]), .ready(ready_w[0]), .cmd(cmd_w[0]),
      .addr(addr_w[0]), .wdata(wdata_w[0]), .rdata(rdata_w[0]), .done(done_w[0]),
      .sck(sck_w[0]), .cs(cs_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0])
   );
   spi_frame_master #(.HALF_DIV(1), .GAP_CYC(1)) u_dut1 (
      .clk(clk), .rst(rst_w[1]), .req(req_w[1]), .ready(ready_w[1]), .cmd(cmd_w[1]),
      .addr(addr_w[1]), .wdata(wdata_w[1]), .rdata(rdata_w[1]), .done(done_w[1]),
      .sck(sck_w[1]), .cs(cs_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1])
   );
   spi_frame_master #(.HALF_DIV(5), .GAP_CYC(4)) u_dut2 (
      .clk(clk), .rst(rst_w[2]), .req(req_w[2]), .ready(ready_w[2]), .cmd(cmd_w[2]),
      .addr(addr_w[2]), .wdata(wdata_w[2]), .rdata(rdata_w[2]), .done(done_w[2]),
      .sck(sck_w[2]), .cs(cs_w[2]), .mosi(mosi_w[2]), .miso(miso_w[2])
   );

   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] miso;
      logic [63:0] exp_frame;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      int          id;
      logic [63:0] frame;
      logic [31:0] rdata;
   } exp_t;

   vec_t vecs [5];
   exp_t sb_q [$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Per-instance monitor state.
   int          rises [3], cslow [3], acc_cyc [3], accepts [3], dones [3];
   int          last_done [3], prev_done [3], high_run [3], last_high_run [3], run [3];
   logic [63:0] cap [3];
   logic [31:0] bsh [3], rd_acc [3], miso_word [3];
   logic        psck [3], pcs [3], pmosi [3], pdone [3], data_ph [3], in_frame [3];
   logic        bad_mosi [3], bad_phase [3], bad_hold [3], bad_sck_csh [3], bad_done_w [3];

   // Slave model: junk during command/address, then the preloaded word MSB first.
   assign miso_w[0] = data_ph[0] ? bsh[0][31] : cyc[0];
   assign miso_w[1] = data_ph[1] ? bsh[1][31] : cyc[0];
   assign miso_w[2] = data_ph[2] ? bsh[2][31] : cyc[0];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk64(input string name, input int k, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[dut%0d]: got %0h, expected %0h", name, k, act, exp);
   endtask

   task automatic chki(input string name, input int k, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s[dut%0d]: got %0d, expected %0d", name, k, act, exp);
   endtask

   task automatic check_frame(input int k);
      exp_t e;
      chki("sb_nonempty", k, int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chki("sb_id", k, e.id, k);
         chk64("frame", k, cap[k], e.frame);
         chk64("rdata", k, 64'(rdata_w[k]), 64'(e.rdata));
         chki("sck_rises", k, rises[k], 64);
         chki("cs_low_cycles", k, cslow[k], 129 * hd_p[k]);
         // Inclusive count: accept cycle through done cycle.
         chki("accept_to_done", k, cyc - acc_cyc[k] + 1, 1 + 129 * hd_p[k] + gap_p[k]);
         chki("mosi_stable_sck_hi", k, int'(bad_mosi[k]), 0);
         chki("sck_phase_len", k, int'(bad_phase[k]), 0);
         chki("rdata_hold", k, int'(bad_hold[k]), 0);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rises[k] = 0; cslow[k] = 0; acc_cyc[k] = 0; accepts[k] = 0; dones[k] = 0;
         last_done[k] = 0; prev_done[k] = 0; high_run[k] = 0; last_high_run[k] = 0;
         run[k] = 0; cap[k] = '0; bsh[k] = '0; rd_acc[k] = '0;
         psck[k] = 1'b0; pcs[k] = 1'b1; pmosi[k] = 1'b0; pdone[k] = 1'b0;
         data_ph[k] = 1'b0; in_frame[k] = 1'b0; bad_mosi[k] = 1'b0; bad_phase[k] = 1'b0;
         bad_hold[k] = 1'b0; bad_sck_csh[k] = 1'b0; bad_done_w[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (req_w[k] === 1'b1 && ready_w[k] === 1'b1) begin
               accepts[k]++;
               acc_cyc[k]  = cyc;
               rises[k]    = 0;
               cslow[k]    = 0;
               cap[k]      = '0;
               bsh[k]      = miso_word[k];
               data_ph[k]  = 1'b0;
               rd_acc[k]   = rdata_w[k];
               in_frame[k] = 1'b1;
               bad_mosi[k] = 1'b0; bad_phase[k] = 1'b0; bad_hold[k] = 1'b0;
            end
            if (cs_w[k] === 1'b1) begin
               high_run[k]++;
               if (!pcs[k] && run[k] != hd_p[k]) bad_phase[k] = 1'b1;
               if (sck_w[k] !== 1'b0) bad_sck_csh[k] = 1'b1;
            end else if (cs_w[k] === 1'b0) begin
               cslow[k]++;
               if (pcs[k]) begin
                  last_high_run[k] = high_run[k];
                  high_run[k] = 0;
                  run[k] = 1;
               end else if (sck_w[k] == psck[k]) begin
                  run[k]++;
               end else begin
                  if (run[k] != hd_p[k]) bad_phase[k] = 1'b1;
                  run[k] = 1;
               end
               if (!pcs[k] && sck_w[k] && mosi_w[k] != pmosi[k]) bad_mosi[k] = 1'b1;
               if (sck_w[k] && !psck[k]) begin
                  cap[k] = {cap[k][62:0], mosi_w[k]};
                  rises[k]++;
               end
               if (!sck_w[k] && psck[k]) begin
                  if (rises[k] >= 32) data_ph[k] = 1'b1;
                  if (rises[k] > 32) bsh[k] = {bsh[k][30:0], 1'b0};
               end
            end
            if (in_frame[k] && done_w[k] !== 1'b1 && rdata_w[k] !== rd_acc[k]) bad_hold[k] = 1'b1;
            if (done_w[k] === 1'b1 && pdone[k]) bad_done_w[k] = 1'b1;
            if (done_w[k] === 1'b1) begin
               dones[k]++;
               prev_done[k] = last_done[k];
               last_done[k] = cyc;
               in_frame[k]  = 1'b0;
               check_frame(k);
            end
            psck[k]  = sck_w[k];
            pcs[k]   = cs_w[k];
            pmosi[k] = mosi_w[k];
            pdone[k] = (done_w[k] === 1'b1);
         end
      end
   end

   task automatic wait_done(input int k, input int budget);
      int  d0;
      bit  got;
      d0  = dones[k];
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         @(posedge clk);
         if (dones[k] != d0) got = 1'b1;
      end
      chki("done_seen", k, int'(got), 1);
   endtask

   task automatic push_exp(input int k, input vec_t v);
      exp_t e;
      e.id    = k;
      e.frame = v.exp_frame;
      e.rdata = v.exp_rdata;
      sb_q.push_back(e);
   endtask

   task automatic load(input int k, input vec_t v);
      miso_word[k] = v.miso;
      cmd_w[k]     = v.cmd;
      addr_w[k]    = v.addr;
      wdata_w[k]   = v.wdata;
   endtask

   task automatic run_frame(input int k, input vec_t v);
      push_exp(k, v);
      load(k, v);
      @(posedge clk); #1 req_w[k] = 1'b1;
      @(posedge clk); #1 req_w[k] = 1'b0;
      // Inputs may change freely once accepted.
      cmd_w[k]   = ~v.cmd;
      addr_w[k]  = 24'($urandom);
      wdata_w[k] = $urandom;
      wait_done(k, 2 * (1 + 129 * hd_p[k] + gap_p[k]) + 20);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  a0, d0;
      bit  got;

      vecs[0] = '{8'hB5, 24'h123456, 32'h00789456, 32'hCAFEF00D, 64'hB512345600789456,
                  32'hCAFEF00D};
      vecs[1] = '{8'h00, 24'h000000, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000,
                  32'hFFFFFFFF};
      vecs[2] = '{8'hFF, 24'hFFFFFF, 32'hFFFFFFFF, 32'h00000000, 64'hFFFFFFFFFFFFFFFF,
                  32'h00000000};
      vecs[3] = '{8'hA5, 24'h5A5A5A, 32'h0F0F0F0F, 32'h12345678, 64'hA55A5A5A0F0F0F0F,
                  32'h12345678};
      vecs[4] = '{8'h3C, 24'h0ABCDE, 32'h11223344, 32'h5555AAAA, 64'h3C0ABCDE11223344,
                  32'h5555AAAA};

      for (int k = 0; k < 3; k++) begin
         rst_w[k] = 1'b1; req_w[k] = 1'b0; cmd_w[k] = '0; addr_w[k] = '0; wdata_w[k] = '0;
         miso_word[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst_w[k] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk64("reset_pins", k, 64'({cs_w[k], sck_w[k], mosi_w[k], ready_w[k], done_w[k]}),
               64'(5'b10010));
         chk64("reset_rdata", k, 64'(rdata_w[k]), 64'h0);
      end

      // Table-driven frames on the default instance.
      for (int i = 0; i < 4; i++) run_frame(0, vecs[i]);

      // Requests while busy are ignored.
      a0 = accepts[0];
      d0 = dones[0];
      push_exp(0, vecs[4]);
      load(0, vecs[4]);
      @(posedge clk); #1 req_w[0] = 1'b1;
      @(posedge clk); #1 req_w[0] = 1'b0;
      repeat (9) @(posedge clk);
      #1 cmd_w[0] = 8'h99; addr_w[0] = 24'h777777; req_w[0] = 1'b1;
      chki("busy_ready_10", 0, int'(ready_w[0]), 0);
      @(posedge clk); #1 req_w[0] = 1'b0;
      repeat (89) @(posedge clk);
      #1 cmd_w[0] = 8'h66; wdata_w[0] = 32'hDEADBEEF; req_w[0] = 1'b1;
      chki("busy_ready_100", 0, int'(ready_w[0]), 0);
      @(posedge clk); #1 req_w[0] = 1'b0;
      wait_done(0, 700);
      repeat (20) @(posedge clk);
      chki("busy_accepts", 0, accepts[0] - a0, 1);
      chki("busy_dones", 0, dones[0] - d0, 1);

      // Reset during bit 20's high phase.
      push_exp(0, vecs[1]);
      load(0, vecs[1]);
      @(posedge clk); #1 req_w[0] = 1'b1;
      @(posedge clk); #1 req_w[0] = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(posedge clk); #1;
         if (sck_w[0] && rises[0] == 20) got = 1'b1;
      end
      chki("reach_bit20_hi", 0, int'(got), 1);
      rst_w[0] = 1'b1;
      @(posedge clk); #1 rst_w[0] = 1'b0;
      chk64("midrst_pins", 0, 64'({cs_w[0], sck_w[0], mosi_w[0], ready_w[0], done_w[0]}),
            64'(5'b10010));
      chk64("midrst_rdata", 0, 64'(rdata_w[0]), 64'h0);
      void'(sb_q.pop_back());
      d0 = dones[0];
      repeat (300) @(posedge clk);
      chki("midrst_no_done", 0, dones[0] - d0, 0);
      run_frame(0, vecs[0]);

      // Back-to-back frames with req held high.
      a0 = accepts[1];
      d0 = dones[1];
      push_exp(1, vecs[3]);
      push_exp(1, vecs[3]);
      load(1, vecs[3]);
      @(posedge clk); #1 req_w[1] = 1'b1;
      for (int n = 0; n < 400 && (accepts[1] - a0) < 2; n++) begin
         @(posedge clk); #1;
      end
      req_w[1] = 1'b0;
      for (int n = 0; n < 400 && (dones[1] - d0) < 2; n++) @(posedge clk);
      chki("b2b_dones", 1, dones[1] - d0, 2);
      // Inclusive count: first done cycle through second done cycle.
      chki("b2b_done_spacing", 1, last_done[1] - prev_done[1] + 1, 132);
      chki("b2b_cs_high_min", 1, int'(last_high_run[1] >= 2), 1);

      // Slow divider instance.
      run_frame(2, vecs[4]);

      repeat (10) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         chki("sck_while_cs_high", k, int'(bad_sck_csh[k]), 0);
         chki("done_single_cycle", k, int'(bad_done_w[k]), 0);
      end
      chki("sb_drained", 0, sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
